// File: rtl/para_to_serial_tx.sv
// para_to_serial_tx: valid/ready parallel-to-serial transmitter with frame markers and zero-bubble reload.
module para_to_serial_tx #(
  parameter int W         = 32,
  parameter bit MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] par_in,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         ser_out,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         frame_start,
  output logic         frame_end,
  output logic         busy
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [W-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic shifting, last, xfer, accept;
  always_comb begin
    shifting    = state_q == SHIFT;
    last        = cnt_q == '0;
    xfer        = shifting && ser_ready;
    load_ready  = !rst && (!shifting || (last && ser_ready));
    accept      = load_valid && load_ready;
    ser_valid   = shifting;
    busy        = shifting;
    ser_out     = shifting && (MSB_FIRST ? shreg_q[W-1] : shreg_q[0]);
    frame_start = shifting && cnt_q == LAST;
    frame_end   = shifting && last;
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    // accept while shifting only happens on the final bit, giving the back-to-back reload
    if (accept) begin
      state_d = SHIFT;
      shreg_d = par_in;
      cnt_d   = LAST;
    end else if (xfer && last) begin
      state_d = IDLE;
    end else if (xfer) begin
      shreg_d = MSB_FIRST ? shreg_q << 1 : shreg_q >> 1;
      cnt_d   = cnt_q - CW'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_para_to_serial_tx.sv
// tb_para_to_serial_tx: scoreboard bench driving an 8-bit MSB-first and a 32-bit LSB-first transmitter.
module tb_para_to_serial_tx;
  logic clk = 0;
  logic rst = 1;
  logic [31:0] par_in[2];
  logic load_valid[2], load_ready[2], ser_out[2], ser_valid[2], ser_ready[2];
  logic frame_start[2], frame_end[2], busy[2];
  typedef struct {logic b; logic fs; logic fe; int idx;} exp_t;
  exp_t sb[2][$];
  logic [31:0] wq[2][$];
  logic [31:0] rec[2];
  int n_cmp = 0, n_err = 0;

  para_to_serial_tx #(.W(8), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst), .par_in(par_in[0][7:0]), .load_valid(load_valid[0]),
    .load_ready(load_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
    .ser_ready(ser_ready[0]), .frame_start(frame_start[0]), .frame_end(frame_end[0]),
    .busy(busy[0]));
  para_to_serial_tx #(.W(32), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .par_in(par_in[1]), .load_valid(load_valid[1]),
    .load_ready(load_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
    .ser_ready(ser_ready[1]), .frame_start(frame_start[1]), .frame_end(frame_end[1]),
    .busy(busy[1]));

  always #5 clk = ~clk;

  function automatic int wd(int d);
    return d ? 32 : 8;
  endfunction

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic fail(string name, int d);
    n_cmp++;
    n_err++;
    $display("FAIL %s dut%0d: timed out at %0t", name, d, $time);
  endtask

  // Reference: each accepted word becomes W expected bits in transmit order.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] w;
    logic have, exp_lr;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        sb[d].delete();
        wq[d].delete();
      end
      have   = sb[d].size() != 0;
      exp_lr = !rst && (!have || (sb[d].size() == 1 && ser_ready[d]));
      chk("ser_valid", d, 32'(ser_valid[d]), 32'(have));
      chk("busy", d, 32'(busy[d]), 32'(have));
      chk("load_ready", d, 32'(load_ready[d]), 32'(exp_lr));
      chk("frame_start", d, 32'(frame_start[d]), have ? 32'(sb[d][0].fs) : 0);
      chk("frame_end", d, 32'(frame_end[d]), have ? 32'(sb[d][0].fe) : 0);
      if (have) chk("ser_out", d, 32'(ser_out[d]), 32'(sb[d][0].b));
      else if (rst) chk("ser_out_rst", d, 32'(ser_out[d]), 0);
      if (!rst) begin
        if (have && ser_ready[d]) begin
          e = sb[d].pop_front();
          rec[d][d ? e.idx : wd(d) - 1 - e.idx] = ser_out[d];
          if (e.fe) chk("word", d, rec[d], wq[d].pop_front());
        end
        if (load_valid[d] && exp_lr) begin
          w = par_in[d] & (d ? 32'hFFFF_FFFF : 32'hFF);
          wq[d].push_back(w);
          for (int i = 0; i < wd(d); i++)
            sb[d].push_back('{d ? w[i] : w[wd(d) - 1 - i], i == 0, i == wd(d) - 1, i});
        end
      end
    end
  end

  task automatic send(int d, logic [31:0] w);
    par_in[d] = w;
    load_valid[d] = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (load_ready[d]) begin
        @(posedge clk);
        #1 load_valid[d] = 0;
        return;
      end
    end
    fail("accept", d);
    load_valid[d] = 0;
  endtask

  task automatic drain(int d);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sb[d].size() == 0) return;
    end
    fail("drain", d);
  endtask

  task automatic check_zero();
    for (int d = 0; d < 2; d++) begin
      chk("rst_ser_out", d, 32'(ser_out[d]), 0);
      chk("rst_ser_valid", d, 32'(ser_valid[d]), 0);
      chk("rst_frame_start", d, 32'(frame_start[d]), 0);
      chk("rst_frame_end", d, 32'(frame_end[d]), 0);
      chk("rst_busy", d, 32'(busy[d]), 0);
      chk("rst_load_ready", d, 32'(load_ready[d]), 0);
    end
  endtask

  initial begin
    logic acc[2];
    par_in     = '{0, 0};
    load_valid = '{0, 0};
    ser_ready  = '{1, 1};
    @(posedge clk);
    #2 check_zero();
    @(posedge clk);
    #1 rst = 0;
    send(0, 32'hA5);
    drain(0);
    send(1, 32'h1);
    drain(1);
    send(0, 32'h0F);
    send(0, 32'hF0);
    drain(0);
    // stall the 32-bit stream on bit 5 with a second word already pending
    send(1, 32'hDEAD_BEEF);
    repeat (4) @(posedge clk);
    #1 ser_ready[1] = 0;
    par_in[1] = 32'h1234_5678;
    load_valid[1] = 1;
    repeat (3) @(posedge clk);
    #1 ser_ready[1] = 1;
    send(1, 32'h1234_5678);
    drain(1);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) acc[d] = load_valid[d] && load_ready[d];
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (!load_valid[d] || acc[d]) begin
          load_valid[d] = $urandom_range(0, 3) != 0;
          par_in[d] = $urandom;
        end
        ser_ready[d] = $urandom_range(0, 3) != 0;
      end
    end
    load_valid = '{0, 0};
    ser_ready  = '{1, 1};
    drain(0);
    drain(1);
    send(0, 32'hFF);
    repeat (3) @(posedge clk);
    #3 rst = 1;
    #1 check_zero();
    @(posedge clk);
    #1 rst = 0;
    send(0, 32'h81);
    drain(0);
    @(posedge clk);
    #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
